// File: rtl/cg_pkg.sv
// Shared definitions for the ALU clock-gate controller: FSM state encoding
// and the activity-level codes driven onto Scale_Sel.
package cg_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_WAKE   = 2'd1,
    ST_ACTIVE = 2'd2
  } cg_state_t;

  typedef enum logic [1:0] {
    SCALE_LOW     = 2'd0,
    SCALE_MIDLOW  = 2'd1,
    SCALE_MIDHIGH = 2'd2,
    SCALE_HIGH    = 2'd3
  } scale_t;

endpackage

// File: rtl/activity_monitor.sv
// Counts accepted ALU operations over a free-running window and, at each
// window boundary, publishes a coarse activity level for clock scaling.
module activity_monitor
  import cg_pkg::*;
#(
  parameter int WINDOW = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Ack,
  output logic [1:0] Scale_Sel
);

  localparam int CW  = $clog2(WINDOW);
  localparam int OPW = CW + 1;

  localparam logic [CW-1:0]  WIN_LAST = CW'(WINDOW - 1);
  localparam logic [OPW-1:0] OPS_MAX  = OPW'(WINDOW);
  localparam logic [OPW-1:0] TH_HIGH  = OPW'((3 * WINDOW) / 4);
  localparam logic [OPW-1:0] TH_MID   = OPW'(WINDOW / 2);
  localparam logic [OPW-1:0] TH_LOW   = OPW'(WINDOW / 4);

  logic [CW-1:0]  r_win_cnt;
  logic [OPW-1:0] r_op_cnt;
  scale_t         r_scale;

  logic           w_wrap;
  logic [OPW-1:0] w_ops_total;
  scale_t         w_level;

  assign w_wrap = (r_win_cnt == WIN_LAST);

  // Op count including this cycle's Ack, saturating so it can never wrap.
  assign w_ops_total = (r_op_cnt == OPS_MAX) ? r_op_cnt
                                             : r_op_cnt + {{CW{1'b0}}, Ack};

  // Map the window's op count onto the four activity levels.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here via the if/else chain ending in a plain else) so no latch is inferred.
  always_comb begin
    if (w_ops_total >= TH_HIGH)     w_level = SCALE_HIGH;
    else if (w_ops_total >= TH_MID) w_level = SCALE_MIDHIGH;
    else if (w_ops_total >= TH_LOW) w_level = SCALE_MIDLOW;
    else                            w_level = SCALE_LOW;
  end

  // Window counter, op counter and the level latched on each wrap edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_win_cnt <= '0;
      r_op_cnt  <= '0;
      r_scale   <= SCALE_LOW;
    end else begin
      r_win_cnt <= w_wrap ? '0 : r_win_cnt + 1'b1;
      r_op_cnt  <= w_wrap ? '0 : w_ops_total;
      if (w_wrap) r_scale <= w_level;
    end
  end

  assign Scale_Sel = r_scale;

endmodule

// File: rtl/clock_gate_controller.sv
// Enable generator for the clock-gating cell in front of the ALU. The ALU
// clock stays off while idle, is woken by Req or Force_On, and operations are
// acknowledged only once the gated clock is known to be running. The
// downstream gate registers Enable, so the gated clock lags Enable by a cycle.
module clock_gate_controller
  import cg_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 8,
  parameter int WAKE_CYCLES  = 2,
  parameter int WINDOW       = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Req,
  input  logic       Force_On,
  output logic       Ack,
  output logic       Enable,
  output logic       Clk_Active,
  output logic [1:0] Scale_Sel
);

  localparam int IW = $clog2(IDLE_TIMEOUT) + 1;
  localparam int WW = $clog2(WAKE_CYCLES) + 1;

  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

  cg_state_t     r_state;
  cg_state_t     w_next_state;
  logic [IW-1:0] r_idle_cnt;
  logic [WW-1:0] r_wake_cnt;
  logic          r_enable;
  logic          r_clk_active;

  logic          w_keep;
  logic          w_wake_done;
  logic          w_idle_done;

  // Force_On and Req both count as "work pending" for waking and idling.
  assign w_keep      = Req | Force_On;
  assign w_wake_done = (r_wake_cnt == WAKE_LAST);
  assign w_idle_done = (r_idle_cnt == IDLE_LAST);

  // State register plus Enable/Clk_Active flops fed from the next state,
  // so both outputs come straight from flops and cannot glitch into the gate.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= ST_OFF;
      r_enable     <= 1'b0;
      r_clk_active <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_enable     <= (w_next_state != ST_OFF);
      r_clk_active <= (w_next_state == ST_ACTIVE);
    end
  end

  // Next-state decision; a pending request on the timeout edge keeps ACTIVE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_OFF:    if (w_keep)                 w_next_state = ST_WAKE;
      ST_WAKE:   if (w_wake_done)            w_next_state = ST_ACTIVE;
      ST_ACTIVE: if (!w_keep && w_idle_done) w_next_state = ST_OFF;
      default:                               w_next_state = ST_OFF;
    endcase
  end

  // Wake and idle counters; each is held at zero outside its own state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wake_cnt <= '0;
      r_idle_cnt <= '0;
    end else begin
      if (r_state == ST_WAKE && !w_wake_done) r_wake_cnt <= r_wake_cnt + 1'b1;
      else                                    r_wake_cnt <= '0;

      if (r_state == ST_ACTIVE && !w_keep && !w_idle_done)
        r_idle_cnt <= r_idle_cnt + 1'b1;
      else
        r_idle_cnt <= '0;
    end
  end

  // Ack is combinational so back-to-back operations complete one per cycle.
  always_comb begin
    Ack = Req & (r_state == ST_ACTIVE);
  end

  assign Enable     = r_enable;
  assign Clk_Active = r_clk_active;

  activity_monitor #(
    .WINDOW (WINDOW)
  ) u_activity_monitor (
    .Clk       (Clk),
    .Reset     (Reset),
    .Ack       (Ack),
    .Scale_Sel (Scale_Sel)
  );

endmodule

// File: tb/tb_clock_gate_controller.sv
// Bench for clock_gate_controller. A behavioural model tracks "clock on",
// remaining wake cycles, consecutive idle edges and per-window op totals;
// a registered-enable gate model stands in for the clockgating cell.
module tb_clock_gate_controller;

  localparam int IDLE_TIMEOUT = 8;
  localparam int WAKE_CYCLES  = 2;
  localparam int WINDOW       = 16;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Req;
  logic       Force_On;
  logic       Ack;
  logic       Enable;
  logic       Clk_Active;
  logic [1:0] Scale_Sel;

  logic       r_gate_q;
  logic       w_gated_clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit m_on;
  int m_wake_left;
  int m_idle;
  int m_cyc;
  int m_ops;
  int m_scale;

  clock_gate_controller #(
    .IDLE_TIMEOUT (IDLE_TIMEOUT),
    .WAKE_CYCLES  (WAKE_CYCLES),
    .WINDOW       (WINDOW)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Req        (Req),
    .Force_On   (Force_On),
    .Ack        (Ack),
    .Enable     (Enable),
    .Clk_Active (Clk_Active),
    .Scale_Sel  (Scale_Sel)
  );

  always #5 Clk = ~Clk;

  // Clock-gating cell: registers Enable, gated clock follows one cycle later.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) r_gate_q <= 1'b0;
    else       r_gate_q <= Enable;
  end
  assign w_gated_clk = Clk & r_gate_q;

  function automatic bit m_active();
    return m_on && (m_wake_left == 0);
  endfunction

  task automatic model_reset();
    m_on = 0; m_wake_left = 0; m_idle = 0;
    m_cyc = 0; m_ops = 0; m_scale = 0;
  endtask

  task automatic model_step(input logic req, input logic fon);
    bit act;
    bit ack;
    int ops;
    int lvl;
    act = m_active();
    ack = req && act;
    ops = m_ops + (ack ? 1 : 0);
    if (m_cyc % WINDOW == WINDOW - 1) begin
      lvl = (ops * 4) / WINDOW;
      m_scale = (lvl > 3) ? 3 : lvl;
      m_ops = 0;
    end else begin
      m_ops = (ops > WINDOW) ? WINDOW : ops;
    end
    m_cyc++;
    if (!m_on) begin
      if (req || fon) begin
        m_on = 1; m_wake_left = WAKE_CYCLES; m_idle = 0;
      end
    end else if (m_wake_left > 0) begin
      m_wake_left--;
    end else if (req || fon) begin
      m_idle = 0;
    end else begin
      m_idle++;
      if (m_idle == IDLE_TIMEOUT) begin
        m_on = 0; m_idle = 0;
      end
    end
  endtask

  // Advance one clock edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge Clk);
    if (Reset) model_reset();
    else       model_step(Req, Force_On);
    #1;
  endtask

  task automatic test_reset();
    Req = 1'b1;
    #1;
    checks++;
    if (Enable !== 1'b0 || Ack !== 1'b0 || Clk_Active !== 1'b0 || Scale_Sel !== 2'd0) begin
      failures++;
      $display("FAIL reset_hold got en=%b ack=%b act=%b scale=%0d exp all 0",
               Enable, Ack, Clk_Active, Scale_Sel);
    end
    tick();
    tick();
    checks++;
    if (Enable !== 1'b0 || Ack !== 1'b0 || Clk_Active !== 1'b0) begin
      failures++;
      $display("FAIL reset_edges got en=%b ack=%b act=%b exp 0 0 0", Enable, Ack, Clk_Active);
    end
    Reset = 1'b0;
    Req   = 1'b0;
    tick();
    checks++;
    if (Enable !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_off got en=%b exp 0", Enable);
    end
  endtask

  task automatic test_wake_latency();
    Req = 1'b1;
    #1;
    checks++;
    if (Enable !== 1'b0 || Ack !== 1'b0) begin
      failures++;
      $display("FAIL wake_pre_edge0 got en=%b ack=%b exp 0 0", Enable, Ack);
    end
    tick(); // edge 0
    checks++;
    if (Enable !== 1'b1 || Ack !== 1'b0 || Clk_Active !== 1'b0 || w_gated_clk !== 1'b0) begin
      failures++;
      $display("FAIL wake_edge0 got en=%b ack=%b act=%b gclk=%b exp 1 0 0 0",
               Enable, Ack, Clk_Active, w_gated_clk);
    end
    tick(); // edge 1
    checks++;
    if (Enable !== 1'b1 || Ack !== 1'b0 || w_gated_clk !== 1'b1) begin
      failures++;
      $display("FAIL wake_edge1 got en=%b ack=%b gclk=%b exp 1 0 1", Enable, Ack, w_gated_clk);
    end
    tick(); // edge 2
    checks++;
    if (Ack !== 1'b1 || Clk_Active !== 1'b1) begin
      failures++;
      $display("FAIL wake_edge2 got ack=%b act=%b exp 1 1", Ack, Clk_Active);
    end
  endtask

  // Continues from an ACTIVE cycle with Req high (left by test_wake_latency).
  task automatic test_idle_timeout();
    tick();
    Req = 1'b0;
    for (int i = 0; i < IDLE_TIMEOUT - 1; i++) begin
      tick();
      checks++;
      if (Enable !== 1'b1 || Clk_Active !== 1'b1) begin
        failures++;
        $display("FAIL idle_early[%0d] got en=%b act=%b exp 1 1", i, Enable, Clk_Active);
      end
    end
    tick();
    checks++;
    if (Enable !== 1'b0 || Clk_Active !== 1'b0 || w_gated_clk !== 1'b1) begin
      failures++;
      $display("FAIL idle_timeout got en=%b act=%b gclk=%b exp 0 0 1",
               Enable, Clk_Active, w_gated_clk);
    end
    tick();
    checks++;
    if (w_gated_clk !== 1'b0) begin
      failures++;
      $display("FAIL idle_gclk_stop got gclk=%b exp 0", w_gated_clk);
    end
  endtask

  task automatic test_timeout_race();
    Req = 1'b1;
    repeat (WAKE_CYCLES + 1) tick();
    Req = 1'b0;
    repeat (IDLE_TIMEOUT - 1) tick();
    Req = 1'b1;
    #1;
    checks++;
    if (Ack !== 1'b1 || Clk_Active !== 1'b1) begin
      failures++;
      $display("FAIL race_ack got ack=%b act=%b exp 1 1", Ack, Clk_Active);
    end
    tick();
    checks++;
    if (Enable !== 1'b1 || Clk_Active !== 1'b1) begin
      failures++;
      $display("FAIL race_stay got en=%b act=%b exp 1 1", Enable, Clk_Active);
    end
    Req = 1'b0;
    repeat (IDLE_TIMEOUT - 1) tick();
    checks++;
    if (Enable !== 1'b1) begin
      failures++;
      $display("FAIL race_restart_idle got en=%b exp 1", Enable);
    end
    tick();
    checks++;
    if (Enable !== 1'b0) begin
      failures++;
      $display("FAIL race_final_off got en=%b exp 0", Enable);
    end
  endtask

  task automatic test_force_on();
    Force_On = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (Enable !== 1'b1 || Ack !== 1'b0) begin
        failures++;
        $display("FAIL force_on[%0d] got en=%b ack=%b exp 1 0", i, Enable, Ack);
      end
    end
    checks++;
    if (Clk_Active !== 1'b1) begin
      failures++;
      $display("FAIL force_active got act=%b exp 1", Clk_Active);
    end
    Force_On = 1'b0;
    repeat (IDLE_TIMEOUT - 1) tick();
    checks++;
    if (Enable !== 1'b1) begin
      failures++;
      $display("FAIL force_release_early got en=%b exp 1", Enable);
    end
    tick();
    checks++;
    if (Enable !== 1'b0) begin
      failures++;
      $display("FAIL force_release_off got en=%b exp 0", Enable);
    end
  endtask

  task automatic test_activity_high();
    Req = 1'b1;
    for (int i = 0; i < 3 * WINDOW; i++) begin
      tick();
      checks++;
      if (Scale_Sel !== 2'(m_scale) || Ack !== (Req && m_active())) begin
        failures++;
        $display("FAIL act_high[%0d] got scale=%0d ack=%b exp %0d %b",
                 i, Scale_Sel, Ack, m_scale, Req && m_active());
      end
    end
    checks++;
    if (Scale_Sel !== 2'd3) begin
      failures++;
      $display("FAIL act_high_level got scale=%0d exp 3", Scale_Sel);
    end
  endtask

  // Entered ACTIVE with Req high and a non-zero Scale_Sel.
  task automatic test_reset_abort();
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (Enable !== 1'b0 || Ack !== 1'b0 || Clk_Active !== 1'b0 || Scale_Sel !== 2'd0) begin
      failures++;
      $display("FAIL abort_async got en=%b ack=%b act=%b scale=%0d exp all 0",
               Enable, Ack, Clk_Active, Scale_Sel);
    end
    model_reset();
    #1;
    Reset = 1'b0;
    tick();
    checks++;
    if (Enable !== 1'b1 || Ack !== 1'b0) begin
      failures++;
      $display("FAIL abort_rewake0 got en=%b ack=%b exp 1 0", Enable, Ack);
    end
    tick();
    checks++;
    if (Ack !== 1'b0) begin
      failures++;
      $display("FAIL abort_rewake1 got ack=%b exp 0", Ack);
    end
    tick();
    checks++;
    if (Ack !== 1'b1) begin
      failures++;
      $display("FAIL abort_rewake2 got ack=%b exp 1", Ack);
    end
  endtask

  task automatic test_activity_quarter();
    for (int i = 0; i < 3 * WINDOW; i++) begin
      Req = (i % 4 == 0);
      #1;
      checks++;
      if (Scale_Sel !== 2'(m_scale) || Ack !== (Req && m_active())) begin
        failures++;
        $display("FAIL act_quarter[%0d] got scale=%0d ack=%b exp %0d %b",
                 i, Scale_Sel, Ack, m_scale, Req && m_active());
      end
      tick();
    end
    checks++;
    if (Scale_Sel !== 2'd1 || Enable !== 1'b1) begin
      failures++;
      $display("FAIL act_quarter_level got scale=%0d en=%b exp 1 1", Scale_Sel, Enable);
    end
  endtask

  task automatic test_activity_idle();
    Req = 1'b0;
    for (int i = 0; i < 3 * WINDOW; i++) begin
      tick();
      checks++;
      if (Scale_Sel !== 2'(m_scale)) begin
        failures++;
        $display("FAIL act_idle[%0d] got scale=%0d exp %0d", i, Scale_Sel, m_scale);
      end
    end
    checks++;
    if (Scale_Sel !== 2'd0 || Enable !== 1'b0) begin
      failures++;
      $display("FAIL act_idle_level got scale=%0d en=%b exp 0 0", Scale_Sel, Enable);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (!(Req && Ack)) begin
        if (!Req) Req = ($urandom_range(0, 5) == 0);
      end else begin
        Req = ($urandom_range(0, 1) == 0);
      end
      if ($urandom_range(0, 24) == 0) Force_On = ~Force_On;
      if ($urandom_range(0, 199) == 0) begin
        #1;
        Reset = 1'b1;
        model_reset();
        #1;
        Reset = 1'b0;
      end
      #1;
      checks++;
      if (Enable !== m_on || Clk_Active !== m_active() ||
          Ack !== (Req && m_active()) || Scale_Sel !== 2'(m_scale)) begin
        failures++;
        $display("FAIL random[%0d] got en=%b act=%b ack=%b scale=%0d exp %b %b %b %0d",
                 i, Enable, Clk_Active, Ack, Scale_Sel,
                 m_on, m_active(), Req && m_active(), m_scale);
      end
      tick();
    end
  endtask

  initial begin
    Reset    = 1'b1;
    Req      = 1'b0;
    Force_On = 1'b0;
    model_reset();
    test_reset();
    test_wake_latency();
    test_idle_timeout();
    test_timeout_race();
    test_force_on();
    test_activity_high();
    test_reset_abort();
    test_activity_quarter();
    test_activity_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
